round_sequencer: RTL and testbench

- Sequencing controller for one memory-game round.
- On a start request it generates a pseudo-random digit sequence whose length depends on the current level, then flashes the digits one at a time to the seven-segment path.
- It then collects the user's punched answers in order and reports win or loose.
- It sits between the level tracker, which supplies the level number and consumes win/loose, and the two seven-segment decoders, which consume flash_num and seg_in_ans.

---
 rtl/game_pkg.sv | 25 ++
 rtl/lfsr8.sv | 25 ++
 rtl/round_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_round_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the memory-game round sequencer.
//   state_t   : round controller states
//   BLANK     : seven-segment code meaning "nothing shown"
//   map_digit : folds a raw 4-bit LFSR nibble into a decimal digit 0..9
package game_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GEN       = 3'd1,
      FLASH_ON  = 3'd2,
      FLASH_OFF = 3'd3,
      ANSWER    = 3'd4,
      WIN       = 3'd5,
      LOSE      = 3'd6
   } state_t;

   localparam logic [3:0] BLANK = 4'hF;

   // Nibbles 10..15 fold down onto 4..9, so every stored digit is decimal.
   function automatic logic [3:0] map_digit(input logic [3:0] raw);
      map_digit = (raw >= 4'd10) ? (raw - 4'd6) : raw;
   endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the digit source.
// Ports:
//   clock : system clock
//   rst   : asynchronous active-low reset, loads SEED
//   state : current 8-bit LFSR contents
module lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       rst,
   output logic [7:0] state
);

   // Shift every cycle; the feedback bit enters at the bottom. SEED must be
   // nonzero or the register locks up at all-zeros.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state <= SEED;
      end else begin
         state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
      end
   end

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer
// Controller for one memory-game round: generates a pseudo-random digit
// sequence sized by the level, flashes it digit by digit, then checks the
// user's punched answers in order and reports win or loose.
// Ports:
//   clock, rst      : clock and asynchronous active-low reset
//   start           : single-cycle pulse, begins a round when not busy
//   log_out         : level-sensitive abort back to IDLE
//   level_num       : current level 0..15, sets the sequence length
//   punch_button    : single-cycle pulse, submits toggle_answer in ANSWER
//   toggle_answer   : user digit 0..9
//   flash_num       : digit being flashed, BLANK when nothing is shown
//   flash_valid     : high while a digit is shown
//   seg_in_ans      : last digit accepted during ANSWER
//   busy            : high in GEN, FLASH_ON, FLASH_OFF and ANSWER
//   win, loose      : high in WIN and LOSE respectively
module round_sequencer
   import game_pkg::*;
#(
   parameter int         MAX_LEN    = 8,
   parameter int         ON_CYCLES  = 25000000,
   parameter int         OFF_CYCLES = 12500000,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       start,
   input  logic       log_out,
   input  logic [3:0] level_num,
   input  logic       punch_button,
   input  logic [3:0] toggle_answer,
   output logic [3:0] flash_num,
   output logic       flash_valid,
   output logic [3:0] seg_in_ans,
   output logic       busy,
   output logic       win,
   output logic       loose
);

   localparam int TIMER_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
   localparam int IW        = $clog2(MAX_LEN);

   localparam logic [TW-1:0] ON_LOAD    = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD   = TW'(OFF_CYCLES - 1);
   localparam logic [4:0]    LEN_CAP_M1 = 5'(MAX_LEN - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] len_m1_q, len_m1_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    seg_d;
   logic          store_en;
   logic [IW-1:0] start_len_m1;
   logic [4:0]    lvl_plus1;
   logic [7:0]    lfsr_state;
   logic [3:0]    gen_digit;
   logic [3:0]    seq_buf [MAX_LEN];

   lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clock (clock),
      .rst   (rst),
      .state (lfsr_state)
   );

   assign gen_digit = map_digit(lfsr_state[3:0]);

   // The round length is kept as len-1 so it fits the index width even when
   // the cap equals MAX_LEN; level+1 is clamped to MAX_LEN-1.
   always_comb begin
      lvl_plus1    = {1'b0, level_num} + 5'd1;
      start_len_m1 = (lvl_plus1 > LEN_CAP_M1) ? IW'(LEN_CAP_M1) : IW'(lvl_plus1);
   end

   // Next-state logic. log_out is applied last so it overrides everything,
   // including a punch that arrives in the same cycle.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_m1_d = len_m1_q;
      timer_d  = timer_q;
      seg_d    = seg_in_ans;
      store_en = 1'b0;

      case (state_q)
         IDLE, WIN, LOSE: begin
            if (start) begin
               state_d  = GEN;
               idx_d    = '0;
               len_m1_d = start_len_m1;
            end
         end
         GEN: begin
            store_en = 1'b1;
            if (idx_q == len_m1_q) begin
               state_d = FLASH_ON;
               idx_d   = '0;
               timer_d = ON_LOAD;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         FLASH_ON: begin
            if (timer_q == '0) begin
               state_d = FLASH_OFF;
               timer_d = OFF_LOAD;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         FLASH_OFF: begin
            if (timer_q == '0) begin
               if (idx_q == len_m1_q) begin
                  state_d = ANSWER;
                  idx_d   = '0;
               end else begin
                  state_d = FLASH_ON;
                  idx_d   = idx_q + IW'(1);
                  timer_d = ON_LOAD;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         ANSWER: begin
            if (punch_button) begin
               seg_d = toggle_answer;
               if (toggle_answer != seq_buf[idx_q]) begin
                  state_d = LOSE;
               end else if (idx_q == len_m1_q) begin
                  state_d = WIN;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (log_out) begin
         state_d  = IDLE;
         idx_d    = '0;
         timer_d  = '0;
         seg_d    = seg_in_ans;
         store_en = 1'b0;
      end
   end

   // State, buffer and registered outputs. Outputs are derived from the
   // next state so they line up with the state they describe. On entry to
   // FLASH_ON the buffer slot is already written because len is at least 2.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         len_m1_q    <= '0;
         timer_q     <= '0;
         flash_num   <= BLANK;
         flash_valid <= 1'b0;
         seg_in_ans  <= 4'd0;
         busy        <= 1'b0;
         win         <= 1'b0;
         loose       <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            seq_buf[i] <= 4'd0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         len_m1_q   <= len_m1_d;
         timer_q    <= timer_d;
         seg_in_ans <= seg_d;
         if (store_en) begin
            seq_buf[idx_q] <= gen_digit;
         end
         flash_valid <= (state_d == FLASH_ON);
         flash_num   <= (state_d == FLASH_ON) ? seq_buf[idx_d] : BLANK;
         busy        <= (state_d == GEN) || (state_d == FLASH_ON) ||
                        (state_d == FLASH_OFF) || (state_d == ANSWER);
         win         <= (state_d == WIN);
         loose       <= (state_d == LOSE);
      end
   end

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer
// Scoreboard bench for round_sequencer with short flash timing. Each round
// pushes the output vectors it anticipates, stamped with the cycle they
// should appear on; a monitor pops one entry per observed output change.
module tb_round_sequencer;

   localparam int         ML   = 8;
   localparam int         ON   = 4;
   localparam int         OFF  = 2;
   localparam logic [7:0] SEED = 8'hA5;
   localparam logic [3:0] BLK  = 4'hF;

   logic       clock = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic       log_out = 1'b0;
   logic [3:0] level_num = 4'd0;
   logic       punch_button = 1'b0;
   logic [3:0] toggle_answer = 4'd0;
   logic [3:0] flash_num;
   logic       flash_valid;
   logic [3:0] seg_in_ans;
   logic       busy;
   logic       win;
   logic       loose;

   round_sequencer #(
      .MAX_LEN    (ML),
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF),
      .LFSR_SEED  (SEED)
   ) dut (
      .clock         (clock),
      .rst           (rst),
      .start         (start),
      .log_out       (log_out),
      .level_num     (level_num),
      .punch_button  (punch_button),
      .toggle_answer (toggle_answer),
      .flash_num     (flash_num),
      .flash_valid   (flash_valid),
      .seg_in_ans    (seg_in_ans),
      .busy          (busy),
      .win           (win),
      .loose         (loose)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Reference LFSR: taps 8,6,5,4, reset to SEED, shifting every cycle.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [3:0] ref_digit(input logic [7:0] s);
      logic [3:0] d;
      d = s[3:0];
      if (d >= 4'd10) d = d - 4'd6;
      return d;
   endfunction

   logic [7:0] model_lfsr;
   always @(posedge clock or negedge rst) begin
      if (!rst) model_lfsr <= SEED;
      else      model_lfsr <= lfsr_step(model_lfsr);
   end

   typedef struct {
      int         cyc;
      logic [3:0] fn;
      logic       fv;
      logic [3:0] seg;
      logic       busy;
      logic       win;
      logic       loose;
   } exp_t;

   exp_t       exp_q [$];
   string      tag_q [$];
   int         errors = 0;
   int         checks = 0;
   logic [3:0] exp_seg = 4'd0;

   task automatic push_exp(input string tag, input int c, input logic [3:0] fn,
                           input logic fv, input logic b, input logic w, input logic l);
      exp_t e;
      e.cyc = c; e.fn = fn; e.fv = fv; e.seg = exp_seg;
      e.busy = b; e.win = w; e.loose = l;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_output(input logic [11:0] cur);
      exp_t       e;
      string      tag;
      logic [11:0] want;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL unexpected_change at cycle %0d: got %h, expected no change", cyc, cur);
         return;
      end
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      want = {e.fn, e.fv, e.seg, e.busy, e.win, e.loose};
      if (cur !== want || (e.cyc >= 0 && e.cyc != cyc)) begin
         errors++;
         $display("[TB] FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                  tag, cur, cyc, want, e.cyc);
      end
      if (flash_valid === 1'b1) begin
         checks++;
         if (flash_num > 4'd9) begin
            errors++;
            $display("[TB] FAIL digit_range: got %0d, expected <= 9", flash_num);
         end
      end
   endtask

   // Monitor: samples just after every falling clock edge and every reset
   // assertion, and consumes one scoreboard entry per output change.
   initial begin
      logic [11:0] cur;
      logic [11:0] prev;
      bit          first;
      first = 1'b1;
      prev  = '0;
      forever begin
         @(negedge clock or negedge rst);
         #1;
         cur = {flash_num, flash_valid, seg_in_ans, busy, win, loose};
         if (first || cur !== prev) check_output(cur);
         prev  = cur;
         first = 1'b0;
      end
   end

   task automatic check_drained(input string tag);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s_drained: got %0d pending events, expected 0", tag, exp_q.size());
         exp_q.delete();
         tag_q.delete();
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clock);
   endtask

   // One round: start at the current negedge, optionally disturb flashing
   // (ignored punch/start, level change), answer with an optional wrong
   // digit, or assert reset after the first answer.
   task automatic apply_stimulus(input string name, input int level, input int wrong_idx,
                                 input bit disturb, input bit reset_mid);
      int         c, len, ans_cyc;
      logic [7:0] m;
      logic [3:0] d [ML];
      logic [3:0] val;
      bit         term;
      c   = cyc;
      len = (level + 2 > ML) ? ML : level + 2;
      m   = model_lfsr;
      for (int i = 0; i < len; i++) begin
         m    = lfsr_step(m);
         d[i] = ref_digit(m);
      end
      start     = 1'b1;
      level_num = 4'(level);
      push_exp({name, "_busy"}, c + 1, BLK, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
         push_exp($sformatf("%s_on%0d", name, i), c + 1 + len + 6 * i, d[i], 1'b1, 1'b1, 1'b0, 1'b0);
         push_exp($sformatf("%s_off%0d", name, i), c + 5 + len + 6 * i, BLK, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clock);
      start = 1'b0;
      if (disturb) begin
         wait_cyc(c + 2 + len);
         punch_button  = 1'b1;
         toggle_answer = 4'((d[0] + 1) % 10);
         start         = 1'b1;
         level_num     = 4'd0;
         @(negedge clock);
         punch_button = 1'b0;
         start        = 1'b0;
      end
      ans_cyc = c + 1 + 7 * len;
      wait_cyc(ans_cyc - 1);
      punch_button  = 1'b1;
      toggle_answer = 4'((d[0] + 1) % 10);
      @(negedge clock);
      for (int j = 0; j < len; j++) begin
         val  = (j == wrong_idx) ? 4'((d[j] + 1) % 10) : d[j];
         term = (j == wrong_idx) || (j == len - 1);
         toggle_answer = val;
         punch_button  = 1'b1;
         if (term) begin
            exp_seg = val;
            if (j == wrong_idx)
               push_exp({name, "_loose"}, cyc + 1, BLK, 1'b0, 1'b0, 1'b0, 1'b1);
            else
               push_exp({name, "_win"}, cyc + 1, BLK, 1'b0, 1'b0, 1'b1, 1'b0);
         end else if (val != exp_seg) begin
            exp_seg = val;
            push_exp($sformatf("%s_ans%0d", name, j), cyc + 1, BLK, 1'b0, 1'b1, 1'b0, 1'b0);
         end
         @(negedge clock);
         punch_button = 1'b0;
         if (term) break;
         if (reset_mid) begin
            exp_seg = 4'd0;
            push_exp({name, "_async_reset"}, cyc, BLK, 1'b0, 1'b0, 1'b0, 1'b0);
            #2 rst = 1'b0;
            repeat (2) @(negedge clock);
            rst = 1'b1;
            repeat (2) @(negedge clock);
            check_drained(name);
            return;
         end
      end
      repeat (4) @(negedge clock);
      check_drained(name);
   endtask

   // log_out during the first flash, together with a start and a punch.
   task automatic abort_round();
      int         c;
      logic [3:0] d0;
      c  = cyc;
      d0 = ref_digit(lfsr_step(model_lfsr));
      start     = 1'b1;
      level_num = 4'd1;
      push_exp("abort_busy", c + 1, BLK, 1'b0, 1'b1, 1'b0, 1'b0);
      push_exp("abort_on0", c + 4, d0, 1'b1, 1'b1, 1'b0, 1'b0);
      push_exp("abort_idle", c + 6, BLK, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      start = 1'b0;
      wait_cyc(c + 5);
      log_out       = 1'b1;
      start         = 1'b1;
      punch_button  = 1'b1;
      toggle_answer = d0;
      @(negedge clock);
      log_out      = 1'b0;
      start        = 1'b0;
      punch_button = 1'b0;
      repeat (6) @(negedge clock);
      check_drained("abort");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      push_exp("reset", -1, BLK, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      repeat (3) @(negedge clock);
      rst = 1'b1;
      repeat (2) @(negedge clock);
      apply_stimulus("basic", 0, -1, 1'b0, 1'b0);
      apply_stimulus("wrong", 0, 1, 1'b0, 1'b0);
      apply_stimulus("cap", 9, -1, 1'b1, 1'b0);
      abort_round();
      apply_stimulus("wrong_first", 3, 0, 1'b1, 1'b0);
      apply_stimulus("midreset", 0, -1, 1'b0, 1'b1);
      apply_stimulus("reseed", 0, -1, 1'b0, 1'b0);
      check_drained("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
